// File: rtl/pixmem_arbiter.sv
// Arbiter sharing a single-port image memory between a high-priority display
// read port and a low-priority loader write port with bounded write starvation.
module pixmem_arbiter #(
  parameter int RAM_WIDTH     = 24,
  parameter int RAM_ADDR_BITS = 16,
  parameter int MAX_WAIT      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_req,
  input  logic [RAM_ADDR_BITS-1:0] rd_addr,
  output logic                     rd_busy,
  output logic [RAM_WIDTH-1:0]     rd_data,
  output logic                     rd_valid,
  output logic                     rd_ovf,
  input  logic                     wr_req,
  input  logic [RAM_ADDR_BITS-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0]     wr_data,
  output logic                     wr_busy,
  output logic                     wr_ack,
  output logic                     wr_ovf,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_di,
  input  logic [RAM_WIDTH-1:0]     mem_do
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t                     state_r, state_next_s;
  logic                       rd_pend_r, wr_pend_r;
  logic [RAM_ADDR_BITS-1:0]   rd_slot_addr_r, wr_slot_addr_r;
  logic [RAM_WIDTH-1:0]       wr_slot_data_r;
  logic [RAM_ADDR_BITS-1:0]   op_addr_r;
  logic [RAM_WIDTH-1:0]       op_data_r;
  logic [3:0]                 wait_cnt_r, wait_cnt_next_s;
  logic                       mem_we_r;
  logic                       rd_data_valid_r, wr_ack_r, rd_ovf_r, wr_ovf_r;
  logic [RAM_WIDTH-1:0]       rd_data_r;
  logic                       grant_rd_s, grant_wr_s;
  logic                       rd_accept_s, wr_accept_s;

  // Next-op selection: reads win unless the write has waited MAX_WAIT grants.
  always_comb begin
    grant_rd_s   = 1'b0;
    grant_wr_s   = 1'b0;
    state_next_s = IDLE;
    case ({rd_pend_r, wr_pend_r})
      2'b10: begin
        grant_rd_s   = 1'b1;
        state_next_s = READ;
      end
      2'b01: begin
        grant_wr_s   = 1'b1;
        state_next_s = WRITE;
      end
      2'b11: begin
        if (wait_cnt_r == MAX_W) begin
          grant_wr_s   = 1'b1;
          state_next_s = WRITE;
        end else begin
          grant_rd_s   = 1'b1;
          state_next_s = READ;
        end
      end
      default: begin
        grant_rd_s   = 1'b0;
        grant_wr_s   = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // A slot accepts a strobe when empty or when it is being drained this edge.
  always_comb begin
    rd_accept_s = rd_req & (~rd_pend_r | grant_rd_s);
    wr_accept_s = wr_req & (~wr_pend_r | grant_wr_s);
  end

  // Starvation counter for the write slot.
  always_comb begin
    wait_cnt_next_s = wait_cnt_r;
    if (!wr_pend_r || grant_wr_s) begin
      wait_cnt_next_s = 4'd0;
    end else if (grant_rd_s && (wait_cnt_r != MAX_W)) begin
      wait_cnt_next_s = wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_next_s = wait_cnt_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      mem_we_r   <= 1'b0;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_next_s;
      mem_we_r   <= (state_next_s == WRITE);
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // Request slots with sticky overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_r      <= 1'b0;
      wr_pend_r      <= 1'b0;
      rd_slot_addr_r <= '0;
      wr_slot_addr_r <= '0;
      wr_slot_data_r <= '0;
      rd_ovf_r       <= 1'b0;
      wr_ovf_r       <= 1'b0;
    end else begin
      if (rd_accept_s) begin
        rd_pend_r      <= 1'b1;
        rd_slot_addr_r <= rd_addr;
      end else if (grant_rd_s) begin
        rd_pend_r <= 1'b0;
      end
      if (wr_accept_s) begin
        wr_pend_r      <= 1'b1;
        wr_slot_addr_r <= wr_addr;
        wr_slot_data_r <= wr_data;
      end else if (grant_wr_s) begin
        wr_pend_r <= 1'b0;
      end
      if (rd_req && !rd_accept_s) begin
        rd_ovf_r <= 1'b1;
      end
      if (wr_req && !wr_accept_s) begin
        wr_ovf_r <= 1'b1;
      end
    end
  end

  // Operation register feeding the memory port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_addr_r <= '0;
      op_data_r <= '0;
    end else if (grant_rd_s) begin
      op_addr_r <= rd_slot_addr_r;
    end else if (grant_wr_s) begin
      op_addr_r <= wr_slot_addr_r;
      op_data_r <= wr_slot_data_r;
    end else begin
      op_addr_r <= op_addr_r;
      op_data_r <= op_data_r;
    end
  end

  // Completion: capture read data / acknowledge write at the end of the op cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r       <= '0;
      rd_data_valid_r <= 1'b0;
      wr_ack_r        <= 1'b0;
    end else begin
      rd_data_valid_r <= (state_r == READ);
      wr_ack_r        <= (state_r == WRITE);
      if (state_r == READ) begin
        rd_data_r <= mem_do;
      end
    end
  end

  assign rd_busy  = rd_pend_r;
  assign wr_busy  = wr_pend_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_data_valid_r;
  assign rd_ovf   = rd_ovf_r;
  assign wr_ack   = wr_ack_r;
  assign wr_ovf   = wr_ovf_r;
  assign mem_we   = mem_we_r;
  assign mem_addr = op_addr_r;
  assign mem_di   = op_data_r;

endmodule
